// File: rtl/motor_drive_ramp.sv
// Multi-channel H-bridge motor driver with a shared PWM timebase.
// Each channel ramps its applied duty toward the commanded target by at most
// RAMP_STEP per PWM period. Reversals pass through a coast dead-time, and
// active braking shorts the bridge (IN1=IN2=1). Every output is registered and
// is derived from next-state values, so the outputs line up with the counter.
module motor_drive_ramp #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int PWM_HZ       = 25_000,
   parameter int DUTY_W       = 10,
   parameter int NCH          = 2,
   parameter int RAMP_STEP    = 8,
   parameter int DEAD_PERIODS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NCH-1:0]        dir,
   input  logic [NCH-1:0]        brake,
   input  logic [NCH*DUTY_W-1:0] speed,
   output logic [2*NCH-1:0]      in,
   output logic [NCH-1:0]        pwm,
   output logic [NCH-1:0]        at_speed,
   output logic                  period_tick
);

   localparam int CNT_MAX = CLK_HZ / PWM_HZ;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int PW      = CW + DUTY_W;
   localparam int DW      = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

   localparam logic [CW-1:0]     CNT_LAST  = CW'(CNT_MAX - 1);
   localparam logic [PW-1:0]     CNT_MAX_P = PW'(CNT_MAX);
   localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
   localparam logic [DW-1:0]     DEAD_LAST = DW'(DEAD_PERIODS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DEAD  = 2'd2,
      BRAKE = 2'd3
   } state_t;

   // Duty target for a channel: zero while coasting, disabled, braking, or
   // while a running channel is being asked to reverse.
   function automatic logic [DUTY_W-1:0] target_of(
      input state_t            st,
      input logic              adir,
      input logic              d,
      input logic              b,
      input logic              e,
      input logic [DUTY_W-1:0] sp
   );
      logic [DUTY_W-1:0] t;
      if ((st == DEAD) || !e || b) begin
         t = '0;
      end else if ((st == RUN) && (d != adir)) begin
         t = '0;
      end else begin
         t = sp;
      end
      return t;
   endfunction

   // One slew-limited step of cur toward tgt; never overshoots, so it can
   // neither wrap below zero nor above full scale.
   function automatic logic [DUTY_W-1:0] ramp_of(
      input logic [DUTY_W-1:0] cur,
      input logic [DUTY_W-1:0] tgt
   );
      logic [DUTY_W-1:0] r;
      if (cur < tgt) begin
         r = ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
      end else if (cur > tgt) begin
         r = ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
      end else begin
         r = cur;
      end
      return r;
   endfunction

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic          tick_r;

   // Next value of the shared period counter (wraps at CNT_MAX-1).
   always_comb begin
      if (cnt_r == CNT_LAST) begin
         cnt_s = '0;
      end else begin
         cnt_s = cnt_r + CW'(1);
      end
   end

   // Shared timebase; tick is high while the counter sits on its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_s;
         tick_r <= (cnt_s == CNT_LAST);
      end
   end

   assign period_tick = tick_r;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      state_t            state_r, state_s;
      logic [DUTY_W-1:0] cur_r, cur_s;
      logic [CW-1:0]     thr_r, thr_s;
      logic [DW-1:0]     dead_r, dead_s;
      logic              adir_r, adir_s;
      logic [1:0]        in_r, in_s;
      logic              pwm_r, pwm_s;
      logic              at_r, at_s;
      logic [DUTY_W-1:0] spd_s, tgt_s, ramp_s, at_tgt_s;
      logic [PW-1:0]     prod_s;
      logic [CW-1:0]     ramp_thr_s;

      assign spd_s = speed[g*DUTY_W +: DUTY_W];

      // Next-state, ramp and output decode for this channel.
      always_comb begin
         state_s  = state_r;
         cur_s    = cur_r;
         thr_s    = thr_r;
         dead_s   = dead_r;
         adir_s   = adir_r;
         tgt_s    = target_of(state_r, adir_r, dir[g], brake[g], en, spd_s);
         ramp_s   = ramp_of(cur_r, tgt_s);
         prod_s   = CNT_MAX_P * PW'(ramp_s);
         ramp_thr_s = prod_s[PW-1:DUTY_W];

         if (brake[g]) begin
            // Brake entry does not wait for the period boundary.
            state_s = BRAKE;
            cur_s   = '0;
            thr_s   = '0;
            dead_s  = '0;
         end else if (tick_r) begin
            case (state_r)
               IDLE: begin
                  cur_s = ramp_s;
                  thr_s = ramp_thr_s;
                  if (tgt_s != '0) begin
                     state_s = RUN;
                     adir_s  = dir[g];
                  end else begin
                     state_s = IDLE;
                  end
               end
               RUN: begin
                  cur_s = ramp_s;
                  thr_s = ramp_thr_s;
                  if ((ramp_s == '0) && (tgt_s == '0)) begin
                     if (dir[g] == adir_r) begin
                        state_s = IDLE;
                     end else begin
                        state_s = DEAD;
                        dead_s  = '0;
                     end
                  end else begin
                     state_s = RUN;
                  end
               end
               DEAD: begin
                  cur_s = '0;
                  thr_s = '0;
                  if (dead_r == DEAD_LAST) begin
                     state_s = IDLE;
                     dead_s  = '0;
                  end else begin
                     dead_s  = dead_r + DW'(1);
                  end
               end
               BRAKE: begin
                  state_s = DEAD;
                  dead_s  = '0;
                  cur_s   = '0;
                  thr_s   = '0;
               end
               default: begin
                  state_s = IDLE;
                  cur_s   = '0;
                  thr_s   = '0;
                  dead_s  = '0;
               end
            endcase
         end else begin
            state_s = state_r;
         end

         at_tgt_s = target_of(state_s, adir_s, dir[g], brake[g], en, spd_s);
         at_s     = (state_s == RUN) && (cur_s == at_tgt_s);

         case (state_s)
            IDLE: begin
               in_s  = 2'b00;
               pwm_s = 1'b0;
            end
            RUN: begin
               in_s  = adir_s ? 2'b10 : 2'b01;
               pwm_s = (cnt_s < thr_s);
            end
            DEAD: begin
               in_s  = 2'b00;
               pwm_s = 1'b0;
            end
            BRAKE: begin
               in_s  = 2'b11;
               pwm_s = 1'b1;
            end
            default: begin
               in_s  = 2'b00;
               pwm_s = 1'b0;
            end
         endcase
      end

      // Channel state and registered bridge outputs.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_r <= IDLE;
            cur_r   <= '0;
            thr_r   <= '0;
            dead_r  <= '0;
            adir_r  <= 1'b1;
            in_r    <= 2'b00;
            pwm_r   <= 1'b0;
            at_r    <= 1'b0;
         end else begin
            state_r <= state_s;
            cur_r   <= cur_s;
            thr_r   <= thr_s;
            dead_r  <= dead_s;
            adir_r  <= adir_s;
            in_r    <= in_s;
            pwm_r   <= pwm_s;
            at_r    <= at_s;
         end
      end

      assign in[2*g +: 2] = in_r;
      assign pwm[g]       = pwm_r;
      assign at_speed[g]  = at_r;
   end

endmodule

// File: tb/tb_motor_drive_ramp.sv
// Self-checking bench for motor_drive_ramp. A reduced clock ratio (100 clocks
// per PWM period) keeps runs short. A per-period behavioural model of each
// channel predicts the outputs, and directed checks use constants taken from
// the ramp and dead-time rules.
module tb_motor_drive_ramp;
   localparam int CM = 100;
   localparam int W  = 10;
   localparam int RS = 8;
   localparam int DP = 4;
   localparam int NC = 2;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DEAD = 2;
   localparam int M_BRK  = 3;

   logic            clk;
   logic            rst;
   logic            en;
   logic [NC-1:0]   dir;
   logic [NC-1:0]   brake;
   logic [NC*W-1:0] speed;
   logic [2*NC-1:0] br_in;
   logic [NC-1:0]   pwm;
   logic [NC-1:0]   at_speed;
   logic            period_tick;

   int total = 0;
   int bad   = 0;
   int hi0   = 0;

   int mcnt;
   bit mtick;
   int md  [NC];
   int mc  [NC];
   int mt  [NC];
   int mdc [NC];
   bit mad [NC];

   motor_drive_ramp #(
      .CLK_HZ(2_500_000), .PWM_HZ(25_000), .DUTY_W(W), .NCH(NC),
      .RAMP_STEP(RS), .DEAD_PERIODS(DP)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .brake(brake), .speed(speed),
      .in(br_in), .pwm(pwm), .at_speed(at_speed), .period_tick(period_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int want(input int ch);
      if (md[ch] == M_DEAD || !en || brake[ch]) return 0;
      if (md[ch] == M_RUN && dir[ch] != mad[ch]) return 0;
      return int'(speed[ch*W +: W]);
   endfunction

   task automatic model_reset();
      mcnt  = 0;
      mtick = 1'b0;
      for (int ch = 0; ch < NC; ch++) begin
         md[ch] = M_IDLE; mc[ch] = 0; mt[ch] = 0; mdc[ch] = 0; mad[ch] = 1'b1;
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int t;
      mtick = (mcnt == CM - 1);
      mcnt  = (mcnt + 1) % CM;
      for (int ch = 0; ch < NC; ch++) begin
         if (brake[ch]) begin
            md[ch] = M_BRK; mc[ch] = 0; mt[ch] = 0; mdc[ch] = 0;
         end else if (mtick) begin
            t = want(ch);
            if (md[ch] == M_IDLE || md[ch] == M_RUN) begin
               if (mc[ch] < t) mc[ch] += (t - mc[ch] < RS) ? (t - mc[ch]) : RS;
               else if (mc[ch] > t) mc[ch] -= (mc[ch] - t < RS) ? (mc[ch] - t) : RS;
               mt[ch] = (CM * mc[ch]) / (1 << W);
               if (md[ch] == M_IDLE && t > 0) begin
                  md[ch] = M_RUN; mad[ch] = dir[ch];
               end else if (md[ch] == M_RUN && mc[ch] == 0 && t == 0) begin
                  if (dir[ch] == mad[ch]) md[ch] = M_IDLE;
                  else begin md[ch] = M_DEAD; mdc[ch] = 0; end
               end
            end else if (md[ch] == M_DEAD) begin
               if (mdc[ch] == DP - 1) begin md[ch] = M_IDLE; mdc[ch] = 0; end
               else mdc[ch]++;
            end else begin
               md[ch] = M_DEAD; mdc[ch] = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [2*NC-1:0] e_in;
      logic [NC-1:0]   e_pwm;
      logic [NC-1:0]   e_at;
      for (int ch = 0; ch < NC; ch++) begin
         case (md[ch])
            M_RUN:   e_in[2*ch +: 2] = mad[ch] ? 2'b10 : 2'b01;
            M_BRK:   e_in[2*ch +: 2] = 2'b11;
            default: e_in[2*ch +: 2] = 2'b00;
         endcase
         e_pwm[ch] = (md[ch] == M_BRK) || (md[ch] == M_RUN && mcnt < mt[ch]);
         e_at[ch]  = (md[ch] == M_RUN) && (mc[ch] == want(ch));
      end
      check_val("in", 32'(br_in), 32'(e_in));
      check_val("pwm", 32'(pwm), 32'(e_pwm));
      check_val("at_speed", 32'(at_speed), 32'(e_at));
      check_val("period_tick", 32'(period_tick), 32'(mcnt == CM - 1));
   endtask

   // One clock: model and DUT both take the edge, outputs compared at negedge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      hi0 += int'(pwm[0]);
   endtask

   task automatic run_ticks(input int n);
      int k = 0;
      while (k < n) begin
         cycle();
         if (mtick) k++;
      end
   endtask

   task automatic align(input int ph);
      while (mcnt != ph) cycle();
   endtask

   task automatic set_speed(input int ch, input int v);
      speed[ch*W +: W] = W'(v);
   endtask

   initial begin
      int k;
      rst = 1'b1; en = 1'b0; dir = '0; brake = '0; speed = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_in", 32'(br_in), 32'd0);
      check_val("rst_pwm", 32'(pwm), 32'd0);
      check_val("rst_at", 32'(at_speed), 32'd0);
      check_val("rst_tick", 32'(period_tick), 32'd0);
      rst = 1'b0;

      // Ramp to 512 forward; channel 1 runs an unrelated random target.
      en = 1'b1; dir = 2'b11;
      set_speed(0, 512);
      set_speed(1, int'($urandom_range(1023, 1)));
      run_ticks(63);
      check_val("ramp_not_yet", 32'(at_speed[0]), 32'd0);
      run_ticks(1);
      check_val("ramp_at_speed", 32'(at_speed[0]), 32'd1);
      check_val("ramp_in", 32'(br_in[1:0]), 32'b10);
      align(CM - 1); hi0 = 0; repeat (CM) cycle();
      check_val("duty_512", 32'(hi0), 32'(CM / 2));

      // Full scale and a mid-period speed change.
      set_speed(0, 1023);
      run_ticks(70);
      align(CM - 1); hi0 = 0; repeat (CM) cycle();
      check_val("duty_max", 32'(hi0), 32'((CM * 1023) / 1024));
      align(CM - 1); hi0 = 0;
      repeat (40) cycle();
      set_speed(0, 300);
      repeat (CM - 40) cycle();
      check_val("duty_midchg", 32'(hi0), 32'((CM * 1023) / 1024));
      hi0 = 0; repeat (CM) cycle();
      check_val("duty_next", 32'(hi0), 32'((CM * (1023 - RS)) / 1024));

      // Reversal from 64: 8 ramp-down ticks, 4 dead ticks, idle, restart.
      set_speed(0, 64);
      run_ticks(130);
      align(50);
      dir[0] = 1'b0;
      run_ticks(8);
      check_val("rev_dead_in", 32'(br_in[1:0]), 32'b00);
      check_val("rev_dead_pwm", 32'(pwm[0]), 32'd0);
      run_ticks(DP);
      check_val("rev_idle_in", 32'(br_in[1:0]), 32'b00);
      run_ticks(1);
      check_val("rev_run_in", 32'(br_in[1:0]), 32'b01);

      // Brake pulse mid-period at 256.
      set_speed(0, 256);
      run_ticks(40);
      align(50);
      brake[0] = 1'b1;
      cycle();
      check_val("brk_in", 32'(br_in[1:0]), 32'b11);
      check_val("brk_pwm", 32'(pwm[0]), 32'd1);
      brake[0] = 1'b0;
      cycle();
      check_val("brk_hold", 32'(br_in[1:0]), 32'b11);
      run_ticks(1);
      check_val("brk_dead", 32'(br_in[1:0]), 32'b00);
      run_ticks(DP);
      check_val("brk_idle", 32'(br_in[1:0]), 32'b00);
      run_ticks(1);
      check_val("brk_restart", 32'(br_in[1:0]), 32'b01);

      // Enable dropped at 40: five ticks down, then idle.
      set_speed(0, 40);
      run_ticks(40);
      check_val("en_at", 32'(at_speed[0]), 32'd1);
      align(50);
      en = 1'b0;
      run_ticks(4);
      check_val("en_ramp_in", 32'(br_in[1:0]), 32'b01);
      check_val("en_ramp_at", 32'(at_speed[0]), 32'd0);
      run_ticks(1);
      check_val("en_idle_in", 32'(br_in[1:0]), 32'b00);
      en = 1'b1;

      // Random traffic on both channels.
      for (int ev = 0; ev < 60; ev++) begin
         for (int ch = 0; ch < NC; ch++) set_speed(ch, int'($urandom_range(1023, 0)));
         dir   = NC'($urandom_range(3, 0));
         en    = ($urandom_range(9, 0) != 0);
         brake = ($urandom_range(11, 0) == 0) ? NC'($urandom_range(3, 1)) : '0;
         repeat ($urandom_range(300, 1)) cycle();
      end
      brake = '0;

      // Asynchronous reset mid-ramp.
      en = 1'b1; dir = 2'b11;
      set_speed(0, 500);
      run_ticks(10);
      align(50);
      rst = 1'b1;
      #1;
      check_val("arst_in", 32'(br_in), 32'd0);
      check_val("arst_pwm", 32'(pwm), 32'd0);
      check_val("arst_at", 32'(at_speed), 32'd0);
      check_val("arst_tick", 32'(period_tick), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      do begin
         cycle();
         k++;
      end while (!period_tick && k < 2 * CM);
      check_val("rst_restart", 32'(k), 32'(CM - 1));
      cycle();
      check_val("rst_rerun_in", 32'(br_in[1:0]), 32'b10);
      check_val("rst_rerun_at", 32'(at_speed[0]), 32'd0);
      run_ticks(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/motor_drive_ramp.md
Name: motor_drive_ramp

Overview:
Multi-channel H-bridge motor driver and successor to the single-channel fixed-ramp driver. A single shared PWM timebase drives NCH channels. Each channel has its own direction, brake and duty command. The block adds three things the previous generation lacked: slew-limited speed ramping, coast dead-time on direction reversal, and active braking. It sits between the car control FSM and the motor-driver board pins.

Parameters:
CLK_HZ, 100_000_000, system clock frequency.
PWM_HZ, 25_000, PWM frequency. CNT_MAX = CLK_HZ/PWM_HZ (4000 at defaults).
DUTY_W, 10, duty command width. Full scale is 2^DUTY_W.
NCH, 2, number of motor channels.
RAMP_STEP, 8, maximum change of the applied duty per PWM period.
DEAD_PERIODS, 4, number of whole PWM periods spent coasting between reversal and restart.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable. When low, every channel's target is 0 and channels ramp down.
dir  in  NCH  per-channel direction; 1 = forward, 0 = reverse
brake  in  NCH  per-channel brake request
speed  in  NCH*DUTY_W  per-channel duty target; channel i uses speed[i*DUTY_W +: DUTY_W]
in  out  2*NCH  H-bridge inputs; in[2i+1:2i] = {IN1,IN2} for channel i
pwm  out  NCH  per-channel bridge enable (PWM)
at_speed  out  NCH  high when the channel is in RUN and cur == target
period_tick  out  1  one-cycle pulse on the last cycle of each PWM period

Behaviour:
- Reset (async): cnt=0, every channel in IDLE, cur=0, thr=0, dead_cnt=0, applied_dir=1. Outputs in=0, pwm=0, at_speed=0, period_tick=0.
- Timebase:
  - Shared cnt runs 0..CNT_MAX-1 and wraps to 0.
  - period_tick is registered and high while cnt==CNT_MAX-1.
  - All ramp steps and state transitions are evaluated on period_tick. The only exception is brake entry.
- Target per channel: target = (en && !brake[i] && state!=DEAD) ? speed_i : 0. In RUN, if dir[i] != applied_dir, target = 0.
- Ramp, on each tick:
  - if cur<target: cur += min(RAMP_STEP, target-cur)
  - if cur>target: cur -= min(RAMP_STEP, cur-target)
  - The arithmetic saturates: there is no wrap below 0 or above 2^DUTY_W-1.
- Duty threshold:
  - Latched on tick as thr = (CNT_MAX*cur_next) >> DUTY_W.
  - The product is computed at clog2(CNT_MAX)+DUTY_W bits.
  - A duty change becomes visible only from the next period. There are no mid-period glitches.
- PWM output: pwm = registered (cnt < thr). 100% duty is never produced (1023 gives 3996/4000 cycles).
- Per-channel FSM:
  - IDLE: in=00, pwm=0. On a tick with target>0: applied_dir<=dir[i], go to RUN.
  - RUN: in=10 if applied_dir=1, in=01 otherwise. pwm from thr. On a tick where cur_next==0 and the target is 0:
    - if dir[i]==applied_dir (plain stop or en low): go to IDLE.
    - otherwise (reversal): go to DEAD with dead_cnt=0.
  - DEAD: in=00, pwm=0, cur held at 0. dead_cnt increments on each tick. On the tick where dead_cnt==DEAD_PERIODS-1, go to IDLE. The restart in the new direction then happens on a later tick.
  - BRAKE: in=11, pwm=1, cur=0, thr=0.
    - Entry: brake[i] high in any state moves the channel to BRAKE on the next clock, without waiting for a tick.
    - Exit: on a tick with brake[i] low, go to DEAD (dead-time always follows brake).
- Simultaneous events:
  - brake has priority over reversal, en and speed.
  - A reversal request withdrawn before cur reaches 0 ramps back up in the original direction with no DEAD.
  - dir changes while in IDLE or DEAD are sampled only at the IDLE->RUN transition.
- Channels are fully independent apart from sharing cnt and tick.
- rst asserted mid-operation forces reset values immediately, including in=00 (coast).

Test Plan:
- Reset then en=1, dir=1, speed0=512, step 8: cur climbs 8 per period and reaches 512 after 64 ticks; at_speed0 rises; in0=10; pwm0 is high for exactly 2000 of 4000 cycles per period.
- speed0=1023 at steady state -> pwm0 high for 3996 cycles per period. speed changed mid-period -> the high time of the current period is unchanged and the new value applies from the next period.
- Channel at 64 forward, dir flipped to 0 -> 8 ramp-down ticks to 0, then 4 DEAD ticks with in=00/pwm=0, then IDLE, then RUN with in=01, ramping from 0.
- brake0 pulsed at cur=256 mid-period -> next clock in0=11, pwm0=1, cur=0. brake released -> DEAD for 4 periods, then restart. Channel 1 is unaffected throughout.
- en dropped at cur=40 -> 5 ticks down to 0, then IDLE with in=00; at_speed is low while ramping.
- rst asserted mid-ramp for 1 cycle -> all outputs 0 asynchronously; after release, cnt restarts at 0 and the ramp restarts from cur=0.
